// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator and
// its consumers (RGB pixel fetch stage, VGA connector).
//   pix_ce          pixel clock enable (into the generator)
//   count_rgb       horizontal position 0..H_TOTAL-1
//   reset_count_rgb vertical position 0..V_TOTAL-1
//   h_sync, v_sync  sync pulses
//   active          visible-area flag
//   line_start      one-clk pulse on entering column 0
//   frame_start     one-clk pulse on entering (0,0)
//   pix_addr        linear visible-pixel address (VGA_PIX_ADDR_EN only)
// Modports: master = generator side, slave = consumer side.
interface vga_timing_gen_if;
  logic        pix_ce;
  logic [10:0] count_rgb;
  logic [9:0]  reset_count_rgb;
  logic        h_sync;
  logic        v_sync;
  logic        active;
  logic        line_start;
  logic        frame_start;
`ifdef VGA_PIX_ADDR_EN
  logic [18:0] pix_addr;
`endif

  modport master (
    input  pix_ce,
    output count_rgb, reset_count_rgb, h_sync, v_sync, active,
           line_start, frame_start
`ifdef VGA_PIX_ADDR_EN
    , output pix_addr
`endif
  );

  modport slave (
    output pix_ce,
    input  count_rgb, reset_count_rgb, h_sync, v_sync, active,
           line_start, frame_start
`ifdef VGA_PIX_ADDR_EN
    , input pix_addr
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@60 Hz VGA raster timing generator.
// Ports:
//   clk    pixel-domain clock (40 MHz nominal)
//   rst_n  asynchronous active-low reset
//   vga    vga_timing_gen_if.master (pix_ce in; positions, syncs, active,
//          line/frame strobes and optional pix_addr out)
// Optional feature: define VGA_PIX_ADDR_EN to add the pix_addr output.
// Every output is registered from the next-state position, so outputs always
// match the counter values presented alongside them.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h, h_nxt;
  logic [9:0]  v, v_nxt;
  logic        h_wrap;
  logic        active_nxt, hs_nxt, vs_nxt;
  logic        hs, vs, act, ls, fs;

  // Next-state position; h_wrap doubles as the line strobe source and is
  // only raised on an enabled edge, so strobes fall when pix_ce is low.
  always_comb begin
    h_nxt  = h;
    v_nxt  = v;
    h_wrap = 1'b0;
    if (vga.pix_ce) begin
      if (h == H_LAST) begin
        h_nxt  = '0;
        h_wrap = 1'b1;
        v_nxt  = (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h_nxt = h + 11'd1;
      end
    end
  end

  always_comb begin
    active_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt     = ((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vs_nxt     = ((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h   <= '0;
      v   <= '0;
      act <= 1'b1;
      hs  <= ~SYNC_POL;
      vs  <= ~SYNC_POL;
      ls  <= 1'b0;
      fs  <= 1'b0;
    end else begin
      h   <= h_nxt;
      v   <= v_nxt;
      act <= active_nxt;
      hs  <= hs_nxt;
      vs  <= vs_nxt;
      ls  <= h_wrap;
      fs  <= h_wrap && (v_nxt == '0);
    end
  end

  assign vga.count_rgb       = h;
  assign vga.reset_count_rgb = v;
  assign vga.h_sync          = hs;
  assign vga.v_sync          = vs;
  assign vga.active          = act;
  assign vga.line_start      = ls;
  assign vga.frame_start     = fs;

`ifdef VGA_PIX_ADDR_EN
  logic [18:0] addr;

  // Incrementing rather than multiplying: the address holds across blanking
  // and the first pixel of the next line is one past the held value. Leaving
  // the last visible pixel clears it for the remainder of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (vga.pix_ce) begin
      if (active_nxt) begin
        addr <= ((h_nxt == '0) && (v_nxt == '0)) ? '0 : addr + 19'd1;
      end else if ((h == H_ACT_LAST) && (v == V_ACT_LAST)) begin
        addr <= '0;
      end
    end
  end

  assign vga.pix_addr = addr;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int unsigned VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if vga0 ();
  vga_timing_gen_if vga1 ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut_pos (.clk(clk), .rst_n(rst_n), .vga(vga0));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut_neg (.clk(clk), .rst_n(rst_n), .vga(vga1));

  int checks = 0;
  int errors = 0;

  // Reference: raster position as an index into the frame, p = v*HT + h.
  int unsigned p = 0;
  bit exp_ls = 1'b0;
  bit exp_fs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned h, v;
    bit hs_on, vs_on, act;
    h = p % HT;
    v = p / HT;
    hs_on = (h >= HA + HF) && (h < HA + HF + HS);
    vs_on = (v >= VA + VF) && (v < VA + VF + VS);
    act   = (h < HA) && (v < VA);
    chk("h", 32'(vga0.count_rgb), h);
    chk("v", 32'(vga0.reset_count_rgb), v);
    chk("hsync_pos", 32'(vga0.h_sync), 32'(hs_on));
    chk("vsync_pos", 32'(vga0.v_sync), 32'(vs_on));
    chk("active", 32'(vga0.active), 32'(act));
    chk("line_start", 32'(vga0.line_start), 32'(exp_ls));
    chk("frame_start", 32'(vga0.frame_start), 32'(exp_fs));
    chk("h_neg", 32'(vga1.count_rgb), h);
    chk("hsync_neg", 32'(vga1.h_sync), 32'(!hs_on));
    chk("vsync_neg", 32'(vga1.v_sync), 32'(!vs_on));
`ifdef VGA_PIX_ADDR_EN
    begin
      int unsigned a;
      if (act) a = v * HA + h;
      else if (v + 1 < VA) a = v * HA + HA - 1;
      else a = 0;
      chk("pix_addr", 32'(vga0.pix_addr), a);
    end
`endif
  endtask

  task automatic step(input bit ce);
    vga0.pix_ce = ce;
    vga1.pix_ce = ce;
    @(posedge clk);
    if (ce) begin
      p = (p + 1) % FT;
      exp_ls = (p % HT) == 0;
      exp_fs = (p == 0);
    end else begin
      exp_ls = 1'b0;
      exp_fs = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    p = 0;
    exp_ls = 1'b0;
    exp_fs = 1'b0;
  endtask

  int act_cnt, vs_cnt, ls_cnt, fs_cnt, guard;

  initial begin
    vga0.pix_ce = 1'b0;
    vga1.pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Reach the first h_sync edge explicitly.
    repeat (HA + HF) step(1'b1);
    chk("hs_first_h", 32'(vga0.count_rgb), HA + HF);
    chk("hs_first_on", 32'(vga0.h_sync), 1);

    // Remainder of one full frame with pix_ce high, tallying strobes/levels.
    act_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < int'(FT); i++) begin
      act_cnt += int'(vga0.active);
      step(1'b1);
      vs_cnt += int'(vga0.v_sync);
      ls_cnt += int'(vga0.line_start);
      fs_cnt += int'(vga0.frame_start);
    end
    chk("frame_active_cnt", act_cnt, HA * VA);
    chk("frame_vsync_cnt", vs_cnt, VS * HT);
    chk("frame_line_cnt", ls_cnt, VT);
    chk("frame_frame_cnt", fs_cnt, 1);
    chk("frame_fs_last", 32'(vga0.frame_start), 1);
    chk("frame_ls_last", 32'(vga0.line_start), 1);

    // Alternating enable.
    for (int i = 0; i < 2 * int'(HT) + 10; i++) step(i[0] == 1'b0);

    // Random enable over a couple of frames.
    for (int i = 0; i < 2 * int'(FT); i++) step($urandom_range(0, 3) != 0);

    // Asynchronous reset mid-frame.
    guard = 0;
    while (p != 5 * HT + 7 && guard < 4 * int'(FT)) begin
      step(1'b1);
      guard++;
    end
    chk("reach_mid", p, 5 * HT + 7);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step(1'b1);
    chk("restart_h", 32'(vga0.count_rgb), 1);
    chk("restart_v", 32'(vga0.reset_count_rgb), 0);

    for (int i = 0; i < int'(FT) + 50; i++) step($urandom_range(0, 1) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 800x600@60 Hz VGA raster timing: horizontal/vertical pixel counters, sync pulses, active-video flag, line/frame strobes and a linear pixel address.
- Sits directly upstream of the RGB pixel fetch stage. `count_rgb` / `reset_count_rgb` feed that stage's column/row inputs. `h_sync` / `v_sync` go to the VGA connector.
- `pix_addr` replaces a free-running fetch index with a raster-locked address, so frame memory cannot drift out of alignment.

## Interface

Parameters
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch
- `H_SYNC`, 128, horizontal sync width
- `H_BP`, 88, horizontal back porch (line total `H_TOTAL` = 1056)
- `V_ACTIVE`, 600, visible lines
- `V_FP`, 1, vertical front porch
- `V_SYNC`, 4, vertical sync width
- `V_BP`, 23, vertical back porch (frame total `V_TOTAL` = 628)
- `SYNC_POL`, 1, asserted level of `h_sync`/`v_sync` (1 = positive)

Ports
- `clk`  in  1  pixel clock domain clock (40 MHz nominal)
- `rst_n`  in  1  asynchronous, active-low reset
- `pix_ce`  in  1  pixel clock enable; the raster advances one pixel per `clk` cycle with `pix_ce`=1
- `count_rgb`  out  11  horizontal position, 0..H_TOTAL-1
- `reset_count_rgb`  out  10  vertical position, 0..V_TOTAL-1
- `h_sync`  out  1  horizontal sync
- `v_sync`  out  1  vertical sync
- `active`  out  1  high when `count_rgb` < H_ACTIVE and `reset_count_rgb` < V_ACTIVE
- `line_start`  out  1  one-`clk` pulse when position enters column 0
- `frame_start`  out  1  one-`clk` pulse when position enters (0,0)
- `pix_addr`  out  19  linear address of current/next visible pixel (only with `VGA_PIX_ADDR_EN`)

## Operation

- Horizontal counter:
  - Increments on each `clk` edge with `pix_ce`=1.
  - At H_TOTAL-1 it wraps to 0 and the vertical counter increments.
- Vertical counter: at V_TOTAL-1, on a horizontal wrap, wraps to 0.
- With `pix_ce`=0, counters, syncs, `active` and `pix_addr` hold. Strobes drop to 0 on the next edge.
- All outputs are registered and decoded from the next-state position, so every output is consistent with the counter values it appears alongside. No decode lag.
- `h_sync` asserted (=`SYNC_POL`) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [840, 967]. Otherwise it is `!SYNC_POL`.
- `v_sync` asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [601, 604], full lines.
- `line_start`: high for exactly one `clk` after the edge that moves h from H_TOTAL-1 to 0.
- `frame_start`: the same, for the transition (1055,627) -> (0,0). It coincides with `line_start`.
- No strobe is issued for the reset-state position.
- Arithmetic: counters are unsigned and wrap explicitly at the totals, never by width overflow. Widths are sized for the defaults. Parameter sets exceeding 2047/1023 are illegal.

## Timing

- Reset (asynchronous assert, synchronous release on `clk`) sets:
  - `count_rgb`=0, `reset_count_rgb`=0, `active`=1
  - `h_sync`=`v_sync`=`!SYNC_POL`
  - `line_start`=`frame_start`=0, `pix_addr`=0
- The first `pix_ce` edge after release moves to (1,0).
- Reset asserted mid-line or mid-frame forces the reset values immediately, with no completion of the current line.
- Latency: zero cycles between counter value and its decoded outputs (same register stage).
- Period with `pix_ce` tied high: line = 1056 `clk`, frame = 663168 `clk`.

## Configuration

- `VGA_PIX_ADDR_EN` defined: port `pix_addr` exists.
  - While `active`, it equals v*H_ACTIVE + h.
  - It increments by 1 with each visible pixel advance and holds through horizontal and vertical blanking.
  - After the last visible pixel (799,599), it is 0 for the rest of the frame.
  - Its range is 0..479999.
- Undefined: the port and its 19-bit register are removed. All other behaviour is identical.

## Test plan

- Reset release, `pix_ce`=1 -> `h_sync` first asserts on the edge where `count_rgb`=840, deasserts at 968; `line_start` pulses after 1056 edges, with `reset_count_rgb`=1.
- Run one full frame -> `v_sync` asserted exactly for rows 601-604 (4×1056 edges); `frame_start` pulses once, 663168 edges after reset, together with `line_start`; `active` high for exactly 480000 edges.
- `pix_ce` toggled 1,0,1,0 -> counters advance every other `clk`; a strobe produced on an enabled edge lasts one `clk`; position totals match the enabled-edge count.
- `rst_n` pulsed low at (500,300) -> all outputs at reset values asynchronously; the raster restarts from (0,0).
- `VGA_PIX_ADDR_EN` defined -> `pix_addr`=0 at (0,0), 799 at (799,0), 800 at (0,1), 479999 at (799,599), 0 at (800,599), held through blanking.
- `SYNC_POL`=0 -> sync outputs inverted, idle high, same positions.
